mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_bus_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// CPU-to-RAM/IO bus controller: decodes RAM, LED and switch addresses and sequences each access.
// Latency: reads strobe mem_ready 3 edges after command, writes 2; commands only taken in IDLE (no queueing).
module mem_bus_ctrl #(
    parameter int         RAM_AW   = 8,
    parameter logic [8:0] LED_ADDR = 9'h100,
    parameter logic [8:0] SW_ADDR  = 9'h140
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [8:0]        mem_addr,
    input  logic [15:0]       w_data,
    output logic [15:0]       r_data,
    output logic              mem_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [15:0]       ram_din,
    input  logic [15:0]       ram_dout,
    input  logic [7:0]        sw,
    output logic [7:0]        led,
    output logic              bus_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_CAP  = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [1:0] CMD_RD  = 2'b01;
    localparam logic [1:0] CMD_WR  = 2'b10;
    localparam logic [1:0] CMD_ILL = 2'b11;

    state_t      state_q;
    logic [8:0]  addr_q;
    logic [15:0] data_q;
    logic [15:0] r_data_q;
    logic [7:0]  led_q;
    logic        bus_err_q;
    logic        mem_ready_q;
    logic        ram_we_q;
    logic [7:0]  sw_meta_q;
    logic [7:0]  sw_sync_q;

    logic        req_unmapped;
    logic        lat_is_ram;
    logic        lat_is_led;
    logic        lat_is_sw;
    logic [15:0] rd_data_d;

    always_comb begin
        req_unmapped = mem_addr[8] && (mem_addr != LED_ADDR) && (mem_addr != SW_ADDR);
        lat_is_ram   = ~addr_q[8];
        lat_is_led   = (addr_q == LED_ADDR);
        lat_is_sw    = (addr_q == SW_ADDR);
        rd_data_d    = 16'h0000;
        if (lat_is_ram) begin
            rd_data_d = ram_dout;
        end else if (lat_is_sw) begin
            rd_data_d = {8'h00, sw_sync_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            r_data_q    <= '0;
            led_q       <= '0;
            bus_err_q   <= 1'b0;
            mem_ready_q <= 1'b0;
            ram_we_q    <= 1'b0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
        end else begin
            sw_meta_q   <= sw;
            sw_sync_q   <= sw_meta_q;
            mem_ready_q <= 1'b0;
            ram_we_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    case (mem_cmd)
                        CMD_RD: begin
                            addr_q  <= mem_addr;
                            state_q <= RD_WAIT;
                            if (req_unmapped) bus_err_q <= 1'b1;
                        end
                        CMD_WR: begin
                            addr_q   <= mem_addr;
                            data_q   <= w_data;
                            ram_we_q <= ~mem_addr[8];
                            state_q  <= WR;
                            if (req_unmapped) bus_err_q <= 1'b1;
                        end
                        CMD_ILL: bus_err_q <= 1'b1;
                        default: state_q <= IDLE;
                    endcase
                end
                // RAM samples ram_addr this edge; its output is captured in RD_CAP.
                RD_WAIT: state_q <= RD_CAP;
                RD_CAP: begin
                    r_data_q    <= rd_data_d;
                    mem_ready_q <= 1'b1;
                    state_q     <= DONE;
                end
                WR: begin
                    if (lat_is_led) led_q <= data_q[7:0];
                    mem_ready_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r_data    = r_data_q;
    assign mem_ready = mem_ready_q;
    assign ram_addr  = addr_q[RAM_AW-1:0];
    assign ram_we    = ram_we_q;
    assign ram_din   = data_q;
    assign led       = led_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl with a behavioural synchronous RAM.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] w_data;
    logic [15:0] r_data;
    logic        mem_ready;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [7:0]  sw;
    logic [7:0]  led;
    logic        bus_err;

    mem_bus_ctrl #(.RAM_AW(8), .LED_ADDR(9'h100), .SW_ADDR(9'h140)) dut (
        .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
        .w_data(w_data), .r_data(r_data), .mem_ready(mem_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_dout(ram_dout), .sw(sw), .led(led), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    logic [15:0] ram_mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0000;
        ram_dout = 16'h0000;
    end
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] rd;
        logic [7:0]  led;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int ready_cnt = 0;
    int we_cnt = 0;
    logic [7:0]  we_addr;
    logic [15:0] we_din;

    logic [15:0] m_rd;
    logic [7:0]  m_led;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per mem_ready pulse and tracks RAM writes.
    always @(negedge clk) begin
        if (ram_we) begin
            we_cnt++;
            we_addr = ram_addr;
            we_din  = ram_din;
        end
        if (mem_ready) begin
            ready_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ready_cycle", cyc, e.cyc);
                chk("r_data", {16'h0, r_data}, {16'h0, e.rd});
                chk("led", {24'h0, led}, {24'h0, e.led});
                chk("bus_err", {31'h0, bus_err}, {31'h0, e.err});
            end
        end
    end

    function automatic logic unmapped(input logic [8:0] a);
        return a[8] && (a != 9'h100) && (a != 9'h140);
    endfunction

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (exp_q.size() != 0 && n < 20);
        if (exp_q.size() != 0) begin
            chk("ready_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic do_read(input logic [8:0] a, input logic [15:0] exp_val);
        exp_t e;
        @(negedge clk);
        if (unmapped(a)) m_err = 1'b1;
        m_rd = exp_val;
        e.cyc = cyc + 3; e.rd = m_rd; e.led = m_led; e.err = m_err;
        exp_q.push_back(e);
        mem_cmd = 2'b01; mem_addr = a;
        @(negedge clk);
        mem_cmd = 2'b00;
        wait_done();
    endtask

    task automatic do_write(input logic [8:0] a, input logic [15:0] d);
        exp_t e;
        @(negedge clk);
        if (unmapped(a)) m_err = 1'b1;
        if (a == 9'h100) m_led = d[7:0];
        e.cyc = cyc + 2; e.rd = m_rd; e.led = m_led; e.err = m_err;
        exp_q.push_back(e);
        mem_cmd = 2'b10; mem_addr = a; w_data = d;
        @(negedge clk);
        mem_cmd = 2'b00;
        wait_done();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; mem_cmd = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        m_rd = 16'h0; m_led = 8'h0; m_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int rc;
        reset = 1'b0; mem_cmd = 2'b00; mem_addr = 9'h0; w_data = 16'h0; sw = 8'h00;
        m_rd = 16'h0; m_led = 8'h0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_r_data", {16'h0, r_data}, 32'h0);
        chk("rst_led", {24'h0, led}, 32'h0);
        chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
        chk("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        reset = 1'b1;

        // RAM write then read-back
        we_cnt = 0;
        do_write(9'h005, 16'hBEEF);
        chk("ram_we_pulses", we_cnt, 1);
        chk("ram_we_addr", {24'h0, we_addr}, 32'h05);
        chk("ram_we_din", {16'h0, we_din}, 32'hBEEF);
        do_read(9'h005, 16'hBEEF);

        // LED write
        we_cnt = 0;
        do_write(9'h100, 16'h12A5);
        chk("led_write_we", we_cnt, 0);
        chk("led_value", {24'h0, led}, 32'hA5);

        // Switch read after synchroniser settles; switch write is a quiet no-op
        sw = 8'h3C;
        repeat (4) @(negedge clk);
        do_read(9'h140, 16'h003C);
        we_cnt = 0;
        do_write(9'h140, 16'hFFFF);
        chk("sw_write_we", we_cnt, 0);
        chk("sw_write_err", {31'h0, bus_err}, 32'h0);

        // Unmapped read, illegal command, sticky error
        do_read(9'h1FF, 16'h0000);
        @(negedge clk);
        rc = ready_cnt;
        mem_cmd = 2'b11;
        @(negedge clk);
        mem_cmd = 2'b00;
        repeat (4) @(negedge clk);
        chk("illegal_no_ready", ready_cnt, rc);
        chk("illegal_err", {31'h0, bus_err}, 32'h1);
        do_write(9'h005, 16'h1234);
        do_read(9'h005, 16'h1234);
        chk("err_sticky", {31'h0, bus_err}, 32'h1);

        // Reset clears the sticky error
        apply_reset();
        @(negedge clk);
        chk("err_cleared", {31'h0, bus_err}, 32'h0);
        chk("rdata_cleared", {16'h0, r_data}, 32'h0);

        // Reset during WR of an LED write aborts it
        rc = ready_cnt;
        mem_cmd = 2'b10; mem_addr = 9'h100; w_data = 16'h00FF;
        @(negedge clk);
        mem_cmd = 2'b00; reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_led", {24'h0, led}, 32'h0);
        chk("abort_no_ready", ready_cnt, rc);
        do_write(9'h100, 16'h0077);

        // Read held for 6 edges: exactly two transactions
        rc = ready_cnt;
        @(negedge clk);
        c0 = cyc;
        begin
            exp_t e;
            m_rd = 16'h1234;
            e.cyc = c0 + 3; e.rd = m_rd; e.led = m_led; e.err = m_err;
            exp_q.push_back(e);
            e.cyc = c0 + 7;
            exp_q.push_back(e);
        end
        mem_cmd = 2'b01; mem_addr = 9'h005;
        repeat (6) @(negedge clk);
        mem_cmd = 2'b00;
        wait_done();
        repeat (4) @(negedge clk);
        chk("held_read_pulses", ready_cnt - rc, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
